// File: rtl/obi_addr_demux_pkg.sv
// Shared types and default address map for the OBI address demultiplexer.
// The pseudo-target ERR always sits one index above the last real target.
package obi_demux_pkg;

  typedef logic [3:0] tgt_idx_t;

  localparam logic [31:0] MEM_BASE = 32'h1000_0000;
  localparam logic [31:0] MEM_MASK = 32'hF000_0000;
  localparam logic [31:0] DBG_BASE = 32'h2000_0000;
  localparam logic [31:0] DBG_MASK = 32'hFF00_0000;

  function automatic tgt_idx_t err_idx(input int num_targets);
    return tgt_idx_t'(num_targets);
  endfunction

endpackage

// File: rtl/obi_addr_demux_decoder.sv
// Combinational priority decoder: lowest matching region index wins,
// no match returns the ERR pseudo-target.
module obi_addr_decoder
  import obi_demux_pkg::*;
#(
  parameter int NUM_TARGETS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter logic [NUM_TARGETS-1:0][ADDR_WIDTH-1:0] REGION_BASE = {DBG_BASE, MEM_BASE},
  parameter logic [NUM_TARGETS-1:0][ADDR_WIDTH-1:0] REGION_MASK = {DBG_MASK, MEM_MASK}
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output tgt_idx_t              o_sel
);

  always_comb begin
    o_sel = err_idx(NUM_TARGETS);
    // Walk downwards so the lowest matching index is the last one written.
    for (int k = NUM_TARGETS - 1; k >= 0; k--) begin
      if ((i_addr & REGION_MASK[k]) == REGION_BASE[k]) begin
        o_sel = tgt_idx_t'(k);
      end
    end
  end

endmodule

// File: rtl/obi_addr_demux.sv
// One-to-N OBI address demultiplexer with outstanding-transaction tracking.
// All in-flight requests belong to one owner; unmapped addresses get a local error.
module obi_addr_demux
  import obi_demux_pkg::*;
#(
  parameter int NUM_TARGETS     = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [NUM_TARGETS-1:0][ADDR_WIDTH-1:0] REGION_BASE = {DBG_BASE, MEM_BASE},
  parameter logic [NUM_TARGETS-1:0][ADDR_WIDTH-1:0] REGION_MASK = {DBG_MASK, MEM_MASK},
  parameter logic [NUM_TARGETS-1:0]                 STRIP_BASE  = '1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   m_req_i,
  output logic                                   m_gnt_o,
  input  logic [ADDR_WIDTH-1:0]                  m_addr_i,
  input  logic                                   m_we_i,
  input  logic [DATA_WIDTH/8-1:0]                m_be_i,
  input  logic [DATA_WIDTH-1:0]                  m_wdata_i,
  output logic                                   m_rvalid_o,
  output logic [DATA_WIDTH-1:0]                  m_rdata_o,
  output logic                                   m_err_o,
  output logic [NUM_TARGETS-1:0]                 s_req_o,
  input  logic [NUM_TARGETS-1:0]                 s_gnt_i,
  output logic [NUM_TARGETS-1:0][ADDR_WIDTH-1:0] s_addr_o,
  output logic                                   s_we_o,
  output logic [DATA_WIDTH/8-1:0]                s_be_o,
  output logic [DATA_WIDTH-1:0]                  s_wdata_o,
  input  logic [NUM_TARGETS-1:0]                 s_rvalid_i,
  input  logic [NUM_TARGETS-1:0][DATA_WIDTH-1:0] s_rdata_i
);

  localparam int       CNT_W = 4;
  localparam tgt_idx_t ERR   = err_idx(NUM_TARGETS);

  logic [CNT_W-1:0] r_cnt_q;
  tgt_idx_t         r_tgt_q;

  tgt_idx_t              w_sel;
  logic                  w_sel_err;
  logic                  w_ok;
  logic                  w_fwd;
  logic                  w_tgt_rvalid;
  logic [DATA_WIDTH-1:0] w_tgt_rdata;

  obi_addr_decoder #(
    .NUM_TARGETS (NUM_TARGETS),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK)
  ) u_decoder (
    .i_addr (m_addr_i),
    .o_sel  (w_sel)
  );

  assign w_sel_err = (w_sel == ERR);
  // No response bypass: a switch of owner waits until the counter is truly empty.
  assign w_ok  = (r_cnt_q == '0) ||
                 ((w_sel == r_tgt_q) && (r_cnt_q < CNT_W'(MAX_OUTSTANDING)));
  assign w_fwd = m_req_i && w_ok;

  always_comb begin
    s_req_o = '0;
    m_gnt_o = 1'b0;
    if (w_sel_err) begin
      m_gnt_o = w_fwd;
    end else begin
      for (int k = 0; k < NUM_TARGETS; k++) begin
        if (w_sel == tgt_idx_t'(k)) begin
          s_req_o[k] = w_fwd;
          m_gnt_o    = w_fwd && s_gnt_i[k];
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_TARGETS; k++) begin : g_addr
    assign s_addr_o[k] = STRIP_BASE[k] ? (m_addr_i - REGION_BASE[k]) : m_addr_i;
  end

  assign s_we_o    = m_we_i;
  assign s_be_o    = m_be_i;
  assign s_wdata_o = m_wdata_i;

  always_comb begin
    w_tgt_rvalid = 1'b0;
    w_tgt_rdata  = '0;
    for (int k = 0; k < NUM_TARGETS; k++) begin
      if (r_tgt_q == tgt_idx_t'(k)) begin
        w_tgt_rvalid = s_rvalid_i[k];
        w_tgt_rdata  = s_rdata_i[k];
      end
    end
  end

  // Responses from any target other than the owner are dropped here.
  assign m_rvalid_o = (r_cnt_q != '0) && ((r_tgt_q == ERR) || w_tgt_rvalid);
  assign m_rdata_o  = (r_tgt_q == ERR) ? '0 : w_tgt_rdata;
  assign m_err_o    = (r_tgt_q == ERR);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt_q <= '0;
      r_tgt_q <= '0;
    end else begin
      if (m_gnt_o) begin
        r_tgt_q <= w_sel;
      end
      case ({m_gnt_o, m_rvalid_o})
        2'b10:   r_cnt_q <= r_cnt_q + CNT_W'(1);
        2'b01:   r_cnt_q <= r_cnt_q - CNT_W'(1);
        default: r_cnt_q <= r_cnt_q;
      endcase
    end
  end

endmodule
